// File: rtl/thread_sched_pkg.sv
// Shared CPU configuration and scheduler types used by the thread scheduler.
// cpu_config fixes the byte-address width; cpu_types holds the per-thread types.
package cpu_config;
  localparam int ADDR_LEN = 32;
endpackage

package cpu_types;
  localparam int DEF_NUM_THREADS = 4;

  typedef logic [$clog2(DEF_NUM_THREADS)-1:0] tid_t;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_READY = 2'd1,
    ST_BUSY  = 2'd2,
    ST_HALT  = 2'd3
  } thread_state_t;
endpackage

// File: rtl/thread_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_tid+1, wrapping,
// and grants the first requesting thread.
module rr_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] req_i,
  input  logic [TID_W-1:0]       last_tid_i,
  output logic                   gnt_valid_o,
  output logic [TID_W-1:0]       gnt_tid_o
);

  // NOTE: every output is given a default before the search loop, so no
  // path through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic [TID_W-1:0] idx;
    gnt_valid_o = 1'b0;
    gnt_tid_o   = last_tid_i;
    idx         = '0;
    // NUM_THREADS is a power of two, so the TID_W-bit add wraps for free.
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = last_tid_i + TID_W'(i);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_tid_o   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Round-robin barrel-thread scheduler: one PC and one state machine per
// hardware thread, one issue per cycle to fetch, re-armed by execute commits.
module thread_sched
  import cpu_types::*;
#(
  parameter int              NUM_THREADS = 4,
  parameter int              TID_W       = $clog2(NUM_THREADS),
  parameter int              PC_W        = cpu_config::ADDR_LEN - 2,
  parameter logic [PC_W-1:0] BOOT_PC     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   fetch_ready_i,
  output logic                   fetch_valid_o,
  output logic [TID_W-1:0]       thread_id_o,
  output logic [PC_W-1:0]        curr_pc_o,
  input  logic                   commit_valid_i,
  input  logic [TID_W-1:0]       commit_tid_i,
  input  logic                   commit_redirect_i,
  input  logic [PC_W-1:0]        commit_pc_i,
  input  logic                   commit_illegal_i,
  output logic [NUM_THREADS-1:0] halted_o
);

  thread_state_t    state_q [NUM_THREADS];
  thread_state_t    state_d [NUM_THREADS];
  logic [PC_W-1:0]  pc_q    [NUM_THREADS];
  logic [PC_W-1:0]  pc_d    [NUM_THREADS];
  logic [TID_W-1:0] last_tid_q, last_tid_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [TID_W-1:0] thread_id_q, thread_id_d;
  logic [PC_W-1:0]  curr_pc_q, curr_pc_d;

  logic [NUM_THREADS-1:0] req;
  logic                   gnt_valid;
  logic [TID_W-1:0]       gnt_tid;
  logic                   issue;

  always_comb begin
    req = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      req[t] = (state_q[t] == ST_READY);
    end
  end

  rr_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_arb (
    .req_i       (req),
    .last_tid_i  (last_tid_q),
    .gnt_valid_o (gnt_valid),
    .gnt_tid_o   (gnt_tid)
  );

  always_comb begin
    issue = fetch_ready_i & gnt_valid;
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];
      case (state_q[t])
        ST_OFF: begin
          if (thread_en_i[t]) begin
            state_d[t] = ST_READY;
            pc_d[t]    = BOOT_PC;
          end
        end
        ST_READY: begin
          if (issue && gnt_tid == TID_W'(t)) begin
            state_d[t] = ST_BUSY;
            pc_d[t]    = pc_q[t] + PC_W'(1);
          end else if (!thread_en_i[t]) begin
            state_d[t] = ST_OFF;
          end
        end
        ST_BUSY: begin
          // The PC was already advanced at issue; only a redirect moves it here.
          if (commit_valid_i && commit_tid_i == TID_W'(t)) begin
            if (commit_illegal_i) begin
              state_d[t] = ST_HALT;
            end else begin
              state_d[t] = thread_en_i[t] ? ST_READY : ST_OFF;
              if (commit_redirect_i) pc_d[t] = commit_pc_i;
            end
          end
        end
        ST_HALT: begin
          if (!thread_en_i[t]) state_d[t] = ST_OFF;
        end
        default: state_d[t] = ST_OFF;
      endcase
    end

    fetch_valid_d = issue;
    thread_id_d   = issue ? gnt_tid : thread_id_q;
    curr_pc_d     = issue ? pc_q[gnt_tid] : curr_pc_q;
    last_tid_d    = issue ? gnt_tid : last_tid_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the PC file is small and software-visible after reset, so it is
      // reset explicitly rather than left uninitialised like a RAM.
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= ST_OFF;
        pc_q[t]    <= '0;
      end
      last_tid_q    <= TID_W'(NUM_THREADS - 1);
      fetch_valid_q <= 1'b0;
      thread_id_q   <= '0;
      curr_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      last_tid_q    <= last_tid_d;
      fetch_valid_q <= fetch_valid_d;
      thread_id_q   <= thread_id_d;
      curr_pc_q     <= curr_pc_d;
    end
  end

  always_comb begin
    halted_o = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      halted_o[t] = (state_q[t] == ST_HALT);
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign thread_id_o   = thread_id_q;
  assign curr_pc_o     = curr_pc_q;

endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: a thread-level reference model predicts
// every issue into a queue; a monitor pops and compares when fetch_valid_o fires.
module tb_thread_sched;

  localparam int NT   = 4;
  localparam int PCW  = 30;
  localparam int M_OFF = 0, M_READY = 1, M_BUSY = 2, M_HALT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NT-1:0]   thread_en_i = '0;
  logic            fetch_ready_i = 1'b0;
  logic            fetch_valid_o;
  logic [1:0]      thread_id_o;
  logic [PCW-1:0]  curr_pc_o;
  logic            commit_valid_i = 1'b0;
  logic [1:0]      commit_tid_i = '0;
  logic            commit_redirect_i = 1'b0;
  logic [PCW-1:0]  commit_pc_i = '0;
  logic            commit_illegal_i = 1'b0;
  logic [NT-1:0]   halted_o;

  thread_sched dut (
    .clk               (clk),
    .rst               (rst),
    .thread_en_i       (thread_en_i),
    .fetch_ready_i     (fetch_ready_i),
    .fetch_valid_o     (fetch_valid_o),
    .thread_id_o       (thread_id_o),
    .curr_pc_o         (curr_pc_o),
    .commit_valid_i    (commit_valid_i),
    .commit_tid_i      (commit_tid_i),
    .commit_redirect_i (commit_redirect_i),
    .commit_pc_i       (commit_pc_i),
    .commit_illegal_i  (commit_illegal_i),
    .halted_o          (halted_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int             tid;
    logic [PCW-1:0] pc;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: thread-level view of the scheduler.
  int             m_st   [NT];
  logic [PCW-1:0] m_pc   [NT];
  int             m_last;
  logic [1:0]     m_out_tid;
  logic [PCW-1:0] m_out_pc;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_st[t] = M_OFF;
      m_pc[t] = '0;
    end
    m_last    = NT - 1;
    m_out_tid = '0;
    m_out_pc  = '0;
    exp_q.delete();
  endtask

  function automatic logic [NT-1:0] exp_halted();
    logic [NT-1:0] h;
    h = '0;
    for (int t = 0; t < NT; t++) h[t] = (m_st[t] == M_HALT);
    return h;
  endfunction

  // Advances the model across one clock edge given the inputs of that cycle.
  task automatic model_step(input logic r, input logic [NT-1:0] en, input logic rdy,
                            input logic cv, input logic [1:0] ct, input logic rd,
                            input logic [PCW-1:0] cp, input logic il);
    int old [NT];
    int g, t;
    bit found;
    exp_t e;
    if (r) begin
      model_reset();
      return;
    end
    old   = m_st;
    found = 0;
    g     = 0;
    for (int k = 1; k <= NT; k++) begin
      t = (m_last + k) % NT;
      if (!found && old[t] == M_READY) begin
        found = 1;
        g     = t;
      end
    end
    if (rdy && found) begin
      e.tid = g;
      e.pc  = m_pc[g];
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      m_out_tid = 2'(g);
      m_out_pc  = m_pc[g];
      m_pc[g]   = m_pc[g] + 30'd1;
      m_st[g]   = M_BUSY;
      m_last    = g;
    end
    if (cv && old[ct] == M_BUSY) begin
      if (il) m_st[ct] = M_HALT;
      else begin
        if (rd) m_pc[ct] = cp;
        m_st[ct] = en[ct] ? M_READY : M_OFF;
      end
    end
    for (int k = 0; k < NT; k++) begin
      if (old[k] == M_OFF && en[k]) begin
        m_st[k] = M_READY;
        m_pc[k] = '0;
      end else if (old[k] == M_READY && m_st[k] == M_READY && !en[k]) begin
        m_st[k] = M_OFF;
      end else if (old[k] == M_HALT && !en[k]) begin
        m_st[k] = M_OFF;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [NT-1:0] en, input logic rdy,
                       input logic cv, input logic [1:0] ct, input logic rd,
                       input logic [PCW-1:0] cp, input logic il);
    @(negedge clk);
    if (mon_en) check("halted_o", 64'(halted_o), 64'(exp_halted()));
    rst               = r;
    thread_en_i       = en;
    fetch_ready_i     = rdy;
    commit_valid_i    = cv;
    commit_tid_i      = ct;
    commit_redirect_i = rd;
    commit_pc_i       = cp;
    commit_illegal_i  = il;
    model_step(r, en, rdy, cv, ct, rd, cp, il);
  endtask

  task automatic idle(input logic [NT-1:0] en, input int n);
    repeat (n) drive(0, en, 1, 0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    repeat (2) drive(1, '0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic run_until_busy(input int t, input logic [NT-1:0] en);
    for (int i = 0; i < 10; i++) begin
      if (m_st[t] == M_BUSY) break;
      drive(0, en, 1, 0, 0, 0, '0, 0);
    end
  endtask

  task automatic commit(input logic [NT-1:0] en, input logic [1:0] t, input logic rd,
                        input logic [PCW-1:0] cp, input logic il);
    drive(0, en, 1, 1, t, rd, cp, il);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    exp_t e;
    bit   due;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (fetch_valid_o) begin
        check("issue_expected", 64'(fetch_valid_o), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("issue_cycle", 64'(cyc), 64'(e.cyc));
          check("issue_tid", 64'(thread_id_o), 64'(e.tid));
          check("issue_pc", 64'(curr_pc_o), 64'(e.pc));
        end
      end else begin
        due = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
        check("issue_present", 64'(fetch_valid_o), 64'(due));
        if (due) void'(exp_q.pop_front());
        check("hold_tid", 64'(thread_id_o), 64'(m_out_tid));
        check("hold_pc", 64'(curr_pc_o), 64'(m_out_pc));
      end
    end
  end

  initial begin
    int wait_n;
    logic [NT-1:0]  en;
    logic [1:0]     ct;
    logic [PCW-1:0] cp;

    model_reset();
    drive(1, '0, 0, 0, 0, 0, '0, 0);
    mon_en = 1;
    drive(1, '0, 0, 0, 0, 0, '0, 0);

    // All threads enabled, no commits: 0,1,2,3 at PC 0 once each, then idle.
    idle(4'b1111, 8);

    // Thread 2 alone, commits two cycles after each issue.
    do_reset();
    wait_n = 0;
    repeat (16) begin
      if (m_st[2] == M_BUSY) wait_n++;
      else wait_n = 0;
      drive(0, 4'b0100, 1, wait_n == 2, 2'd2, 0, '0, 0);
      if (wait_n == 2) wait_n = 0;
    end

    // Thread 1 redirect to 0x40, then redirect to all-ones and wrap to 0.
    do_reset();
    run_until_busy(1, 4'b0010);
    commit(4'b0010, 2'd1, 1, 30'h40, 0);
    idle(4'b0010, 3);
    commit(4'b0010, 2'd1, 1, '1, 0);
    idle(4'b0010, 3);
    commit(4'b0010, 2'd1, 0, '0, 0);
    idle(4'b0010, 3);

    // Thread 3 illegal: halts, stays halted, re-enable restarts at PC 0.
    do_reset();
    run_until_busy(3, 4'b1000);
    commit(4'b1000, 2'd3, 0, '0, 1);
    idle(4'b1000, 4);
    idle(4'b0000, 1);
    idle(4'b1000, 4);

    // Fetch stalled with threads 0 and 1 ready.
    do_reset();
    repeat (7) drive(0, 4'b0011, 0, 0, 0, 0, '0, 0);
    idle(4'b0011, 4);

    // Reset with threads 0 and 2 in flight; late commits must be ignored.
    do_reset();
    idle(4'b0101, 4);
    drive(1, 4'b0101, 1, 1, 2'd0, 0, '0, 0);
    commit(4'b0000, 2'd0, 0, '0, 0);
    commit(4'b0000, 2'd2, 1, 30'h55, 0);
    idle(4'b0000, 3);
    idle(4'b0101, 4);

    // Randomised traffic.
    do_reset();
    repeat (400) begin
      for (int t = 0; t < NT; t++) en[t] = ($urandom_range(0, 9) != 0);
      ct = 2'($urandom_range(0, NT - 1));
      cp = PCW'($urandom());
      drive($urandom_range(0, 99) == 0, en, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, ct, $urandom_range(0, 3) == 0,
            cp, $urandom_range(0, 19) == 0);
    end

    idle(4'b0000, 3);
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
